// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, result as a-b mod 2^WIDTH plus final borrow.
// Busy for WIDTH+1 cycles per operation (WIDTH shift cycles plus one DONE cycle); start is ignored while busy.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic w_ai;
  logic w_bi;
  logic w_d;
  logic w_br_nxt;
  logic w_last;

  assign w_ai     = r_a[0];
  assign w_bi     = r_b[0];
  assign w_d      = w_ai ^ w_bi ^ r_br;
  assign w_br_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_last   = (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs only update on the final shift, so partial results never reach diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_part   <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_part <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          r_a    <= {1'b0, r_a[WIDTH-1:1]};
          r_b    <= {1'b0, r_b[WIDTH-1:1]};
          r_part <= {w_d, r_part[WIDTH-1:1]};
          r_br   <= w_br_nxt;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff   <= {w_d, r_part[WIDTH-1:1]};
            r_borrow <= w_br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

endmodule
